// File: rtl/alu_pkg.sv
// Shared ALU arbiter definitions: ALU control codes, sequencer state, pointer helper.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_BRCMP = 3'b111;

    // Requester index width; covers the full 2..4 requester range.
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Next requester index in round-robin order, wrapping at n.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin grant: first valid request at or after ptr, scanning upward with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own accept condition.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    always_comb begin
        logic [IDX_W-1:0] pos;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        pos     = ptr;
        // Step k visits requester (ptr + k) mod NUM_REQ; the first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_vld && req[i] && (pos == IDX_W'(i))) begin
                    gnt_vld = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
            pos = rr_next(pos, NUM_REQ);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters; optional grant lock via ALU_ARB_LOCK_EN.
// Latency: accept in N, operands on alu_* in N+1, rsp_valid in N+2; one op per 2 cycles sustained.
// Backpressure: a held response (rsp_ready low at owner) blocks all new accepts.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_ctrl,
    input  logic [NUM_REQ-1:0]       req_lock,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_ctrl,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_zero,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_zero
);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [NUM_REQ-1:0] owner_oh;
    logic               arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic               owner_rdy;
    logic               can_accept;
    logic               accept;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [2:0]         sel_ctrl;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Owner is kept one-hot so its rsp_ready bit is picked without an index select.
    assign owner_rdy = |(rsp_ready & owner_oh);

    always_comb begin
        state_nxt  = state;
        can_accept = 1'b0;
        case (state)
            ST_IDLE: can_accept = arb_en;
            ST_EXEC: state_nxt  = ST_RESP;
            ST_RESP: begin
                can_accept = owner_rdy;
                if (owner_rdy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        accept = can_accept && gnt_vld;
        if (accept) state_nxt = ST_EXEC;
    end

    assign req_ready = can_accept ? gnt : '0;
    assign rsp_valid = (state == ST_RESP) ? owner_oh : '0;

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a    = req_a[i*WIDTH +: WIDTH];
                sel_b    = req_b[i*WIDTH +: WIDTH];
                sel_ctrl = req_ctrl[i*3 +: 3];
            end
        end
    end

`ifdef ALU_ARB_LOCK_EN
    logic sel_lock;
    assign sel_lock = |(gnt & req_lock);
    // A locking winner keeps top priority for the following arbitration.
    assign ptr_nxt  = sel_lock ? gnt_idx : rr_next(gnt_idx, NUM_REQ);
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign ptr_nxt     = rr_next(gnt_idx, NUM_REQ);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Holds req_ready low while reset is asserted even with requests pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_en <= 1'b0;
        end else begin
            arb_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            owner_oh <= NUM_REQ'(1);
            ptr      <= '0;
        end else if (accept) begin
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_ctrl <= sel_ctrl;
            owner_oh <= gnt;
            ptr      <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural shared ALU attached to alu_*.
// Expected results are queued on request handshake and compared on response handshake.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 32;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid, req_ready, req_lock, rsp_valid, rsp_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
    logic [NUM_REQ*3-1:0]     req_ctrl;
    logic [WIDTH-1:0]         alu_a, alu_b, alu_result, rsp_result;
    logic [2:0]               alu_ctrl;
    logic                     alu_zero, rsp_zero;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       c;
        logic             lock;
    } op_t;

    typedef struct packed {
        int               owner;
        logic [WIDTH-1:0] res;
        logic             zero;
        int               acc;
    } exp_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sbq[$];
    int   gnt_log[$];
    int   acc_log[$];
    logic [NUM_REQ-1:0] hs;
    logic [NUM_REQ-1:0] prev_rsp;
    logic [WIDTH-1:0]   last_res;
    logic               last_zero;
    logic [NUM_REQ-1:0] last_rsp;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [WIDTH:0] alu_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [2:0] c);
        logic [WIDTH-1:0] r;
        case (c)
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_OR:    r = a | b;
            ALU_AND:   r = a & b;
            ALU_SLT:   r = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            ALU_BRCMP: r = a - b;
            default:   r = '0;
        endcase
        return {(r == '0), r};
    endfunction

    assign {alu_zero, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

    alu_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .req_lock   (req_lock),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] c, input logic l);
        op_t o;
        o.a = a; o.b = b; o.c = c; o.lock = l;
        if (r == 0) q0.push_back(o);
        else        q1.push_back(o);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sbq.size() != 0 || req_valid != '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 64'(n >= budget), 0);
    endtask

    // Requester driver: retire the head op after a handshake, present the next one.
    initial begin
        req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0; req_lock = '0;
        forever begin
            @(posedge clk);
            #1;
            if (hs[0] && q0.size() != 0) q0.delete(0);
            if (hs[1] && q1.size() != 0) q1.delete(0);
            hs = '0;
            req_valid = {q1.size() != 0, q0.size() != 0};
            if (q0.size() != 0) begin
                req_a[0 +: WIDTH] = q0[0].a; req_b[0 +: WIDTH] = q0[0].b;
                req_ctrl[0 +: 3] = q0[0].c;  req_lock[0] = q0[0].lock;
            end else begin
                req_a[0 +: WIDTH] = '0; req_b[0 +: WIDTH] = '0; req_ctrl[0 +: 3] = '0; req_lock[0] = 1'b0;
            end
            if (q1.size() != 0) begin
                req_a[WIDTH +: WIDTH] = q1[0].a; req_b[WIDTH +: WIDTH] = q1[0].b;
                req_ctrl[3 +: 3] = q1[0].c;      req_lock[1] = q1[0].lock;
            end else begin
                req_a[WIDTH +: WIDTH] = '0; req_b[WIDTH +: WIDTH] = '0; req_ctrl[3 +: 3] = '0; req_lock[1] = 1'b0;
            end
        end
    end

    // Monitor: push expectations on accept, compare on response.
    initial begin
        exp_t e;
        logic [WIDTH:0] m;
        prev_rsp = '0;
        hs = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rsp = '0;
                continue;
            end
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 0);
                end else begin
                    if (prev_rsp == '0) begin
                        check("rsp_latency", 64'(cyc), 64'(sbq[0].acc + 2));
                        check("rsp_owner", 64'(rsp_valid), 64'(2'b01 << sbq[0].owner));
                    end
                    if ((rsp_valid & rsp_ready) != '0) begin
                        check("rsp_result", 64'(rsp_result), 64'(sbq[0].res));
                        check("rsp_zero", 64'(rsp_zero), 64'(sbq[0].zero));
                        last_res  = rsp_result;
                        last_zero = rsp_zero;
                        last_rsp  = rsp_valid;
                        sbq.delete(0);
                    end
                end
            end
            prev_rsp = rsp_valid;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    m = alu_model(req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], req_ctrl[i*3 +: 3]);
                    e.owner = i; e.res = m[WIDTH-1:0]; e.zero = m[WIDTH]; e.acc = cyc;
                    sbq.push_back(e);
                    gnt_log.push_back(i);
                    acc_log.push_back(cyc);
                    hs[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] codes [6];
        int exp_seq [5];
        int n;
        codes[0] = ALU_ADD; codes[1] = ALU_SUB; codes[2] = ALU_OR;
        codes[3] = ALU_AND; codes[4] = ALU_SLT; codes[5] = ALU_BRCMP;
        rsp_ready = '0;
        rst_n = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 0);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 0);
        check("rst_alu_a", 64'(alu_a), 0);
        check("rst_rsp_result", 64'(rsp_result), 0);
        check("rst_rsp_zero", 64'(rsp_zero), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 2'b11;

        // Single ADD from requester 0.
        push(0, 32'd5, 32'd7, ALU_ADD, 1'b0);
        wait_idle(50);
        check("t1_result", 64'(last_res), 12);
        check("t1_zero", 64'(last_zero), 0);
        check("t1_owner", 64'(last_rsp), 2'b01);

        // Both requesters busy: grants alternate starting at requester 1 (ptr moved past 0).
        gnt_log.delete(); acc_log.delete();
        for (int k = 0; k < 4; k++) begin
            push(0, $urandom, $urandom, codes[$urandom_range(0, 5)], 1'b0);
            push(1, $urandom, $urandom, codes[$urandom_range(0, 5)], 1'b0);
        end
        wait_idle(100);
        check("t2_count", 64'(gnt_log.size()), 8);
        for (int k = 0; k < gnt_log.size(); k++) check($sformatf("t2_gnt%0d", k), 64'(gnt_log[k]), 64'((k + 1) % 2));
        for (int k = 1; k < acc_log.size(); k++) check("t2_spacing", 64'(acc_log[k] - acc_log[k-1]), 2);

        // Requester 1 response held; requester 0 waits behind it.
        gnt_log.delete();
        rsp_ready = 2'b01;
        push(1, 32'd9, 32'd9, ALU_SUB, 1'b0);
        push(0, 32'd3, 32'd4, ALU_OR, 1'b0);
        n = 0;
        while (rsp_valid != 2'b10 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_wait_timeout", 64'(n >= 20), 0);
        repeat (5) begin
            @(negedge clk);
            check("t3_rsp_valid", 64'(rsp_valid), 2'b10);
            check("t3_result", 64'(rsp_result), 0);
            check("t3_zero", 64'(rsp_zero), 1);
            check("t3_req_ready", 64'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        wait_idle(50);
        check("t3_count", 64'(gnt_log.size()), 2);
        if (gnt_log.size() == 2) check("t3_order", 64'({gnt_log[0][0], gnt_log[1][0]}), 2'b10);

        // Reset during EXEC drops the op and restarts arbitration at requester 0.
        push(0, 32'd20, 32'd6, ALU_SUB, 1'b0);
        n = 0;
        while (!(req_valid[0] && req_ready[0]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_wait_timeout", 64'(n >= 20), 0);
        @(posedge clk); #1;
        check("t4_alu_ctrl_exec", 64'(alu_ctrl), 64'(ALU_SUB));
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_rst_rsp_valid", 64'(rsp_valid), 0);
        check("t4_rst_req_ready", 64'(req_ready), 0);
        check("t4_rst_alu_ctrl", 64'(alu_ctrl), 0);
        check("t4_rst_alu_a", 64'(alu_a), 0);
        sbq.delete(); q0.delete(); q1.delete(); hs = '0;
        push(0, 32'd1, 32'd2, ALU_AND, 1'b0);
        push(1, 32'd8, 32'd3, ALU_SLT, 1'b0);
        repeat (2) @(negedge clk);
        check("t4_rst_req_ready_pending", 64'(req_ready), 0);
        gnt_log.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle(50);
        check("t4_count", 64'(gnt_log.size()), 2);
        if (gnt_log.size() > 0) check("t4_first_gnt", 64'(gnt_log[0]), 0);

        // Lock sequence: requester 1 marks three ops locked while requester 0 is also busy.
        push(0, 32'd11, 32'd11, ALU_BRCMP, 1'b0);
        wait_idle(50);
        gnt_log.delete();
        push(0, 32'd4, 32'd5, ALU_ADD, 1'b0);
        push(0, 32'd6, 32'd6, ALU_BRCMP, 1'b0);
        push(1, 32'd7, 32'd2, ALU_SUB, 1'b1);
        push(1, 32'hffff_ffff, 32'd1, ALU_SLT, 1'b1);
        push(1, 32'hf0, 32'h0f, ALU_OR, 1'b1);
        wait_idle(100);
`ifdef ALU_ARB_LOCK_EN
        exp_seq = '{1, 1, 1, 0, 0};
`else
        exp_seq = '{1, 0, 1, 0, 1};
`endif
        check("t5_count", 64'(gnt_log.size()), 5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++)
            check($sformatf("t5_gnt%0d", k), 64'(gnt_log[k]), 64'(exp_seq[k]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
